// File: rtl/my7seg_pkg.sv
// Shared types and constants for the my7seg display back end: digit-byte and
// control-byte field positions plus the active-high hex-to-segment table.
package my7seg_pkg;

    typedef logic [6:0] seg_pat_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam int VAL_LSB         = 0;
    localparam int DP_BIT          = 4;
    localparam int BLANK_BIT       = 5;
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BRIGHT_LSB = 1;
    localparam int CTRL_BRIGHT_MSB = 4;

    // Segment order is {g,f,e,d,c,b,a}; a set bit means the segment is lit.
    localparam seg_pat_t HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_pat_t hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/my7seg_hex_decoder.sv
// Combinational nibble to active-high 7-segment pattern lookup.
module my7seg_hex_decoder
    import my7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_pat_t   pattern
);

    // Table lookup; polarity is applied later in the output register.
    always_comb begin
        pattern = hex_to_seg(nibble);
    end

endmodule

// File: rtl/my7seg_scan_driver.sv
// Multiplexed 7-segment scan driver: digit scan with guard window, 16-level
// PWM brightness and frame-aligned shadow loading of the digit registers.
module my7seg_scan_driver
    import my7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 100000,
    parameter int GUARD_CYC      = 2,
    parameter bit ACTIVE_LOW_AN  = 1'b1,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [8*NUM_DIGITS-1:0]   digit_i,
    input  logic [7:0]                ctrl_i,
    input  logic                      update_i,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic                      frame_tick_o
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [NUM_DIGITS-1:0]   AN_POL      = {NUM_DIGITS{ACTIVE_LOW_AN}};
    localparam logic [6:0]              SEG_POL     = {7{ACTIVE_LOW_SEG}};
    localparam logic [8*NUM_DIGITS-1:0] SHADOW_INIT = {NUM_DIGITS{8'h20}};

    scan_state_t                      state_r;
    logic [PRESC_W-1:0]               presc_r;
    logic [IDX_W-1:0]                 idx_r;
    logic [3:0]                       pwm_r;
    logic                             pending_r;
    logic [NUM_DIGITS-1:0][7:0]       shadow_r;

    logic [NUM_DIGITS-1:0]            an_r;
    logic [6:0]                       seg_r;
    logic                             dp_r;
    logic                             frame_tick_r;

    logic                             scan_run_s;
    logic                             presc_last_s;
    logic                             idx_last_s;
    logic                             frame_end_s;
    logic                             lit_s;
    logic [7:0]                       cur_byte_s;
    seg_pat_t                         hex_pat_s;
    logic [NUM_DIGITS-1:0]            an_act_s;
    logic [6:0]                       seg_act_s;
    logic                             dp_act_s;

    my7seg_hex_decoder u_hex_decoder (
        .nibble  (cur_byte_s[VAL_LSB +: 4]),
        .pattern (hex_pat_s)
    );

    // Slot timing, lit condition and active-high drive levels for the current digit.
    always_comb begin
        scan_run_s   = (state_r == ST_SCAN) && ctrl_i[CTRL_EN_BIT];
        presc_last_s = (presc_r == PRESC_W'(SCAN_DIV - 1));
        idx_last_s   = (idx_r == IDX_W'(NUM_DIGITS - 1));
        frame_end_s  = scan_run_s && presc_last_s && idx_last_s;
        cur_byte_s   = shadow_r[idx_r];
        lit_s        = scan_run_s
                    && (presc_r >= PRESC_W'(GUARD_CYC))
                    && (pwm_r <= ctrl_i[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB])
                    && !cur_byte_s[BLANK_BIT];
        if (lit_s) begin
            an_act_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;
        end else begin
            an_act_s = '0;
        end
        // Segments follow the slot's digit through the guard window so they settle first.
        if (scan_run_s) begin
            seg_act_s = hex_pat_s;
            dp_act_s  = cur_byte_s[DP_BIT];
        end else begin
            seg_act_s = 7'h00;
            dp_act_s  = 1'b0;
        end
    end

    // Scan state machine, prescaler/index/PWM counters and shadow register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r   <= ST_IDLE;
            presc_r   <= '0;
            idx_r     <= '0;
            pwm_r     <= 4'd0;
            pending_r <= 1'b0;
            shadow_r  <= SHADOW_INIT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_r <= '0;
                    idx_r   <= '0;
                    pwm_r   <= 4'd0;
                    if (update_i) begin
                        shadow_r  <= digit_i;
                        pending_r <= 1'b0;
                    end
                    if (ctrl_i[CTRL_EN_BIT]) begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!ctrl_i[CTRL_EN_BIT]) begin
                        state_r <= ST_IDLE;
                        presc_r <= '0;
                        idx_r   <= '0;
                        pwm_r   <= 4'd0;
                        if (update_i) begin
                            pending_r <= 1'b1;
                        end
                    end else begin
                        pwm_r <= pwm_r + 4'd1;
                        if (presc_last_s) begin
                            presc_r <= '0;
                            idx_r   <= idx_last_s ? '0 : idx_r + IDX_W'(1);
                        end else begin
                            presc_r <= presc_r + PRESC_W'(1);
                        end
                        // A write in the wrap cycle itself is taken in the same load.
                        if (frame_end_s && (pending_r || update_i)) begin
                            shadow_r  <= digit_i;
                            pending_r <= 1'b0;
                        end else if (update_i) begin
                            pending_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    presc_r <= '0;
                    idx_r   <= '0;
                    pwm_r   <= 4'd0;
                end
            endcase
        end
    end

    // Output registers with pin polarity folded in.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            an_r         <= AN_POL;
            seg_r        <= SEG_POL;
            dp_r         <= ACTIVE_LOW_SEG;
            frame_tick_r <= 1'b0;
        end else begin
            an_r         <= an_act_s ^ AN_POL;
            seg_r        <= seg_act_s ^ SEG_POL;
            dp_r         <= dp_act_s ^ ACTIVE_LOW_SEG;
            frame_tick_r <= scan_run_s && (presc_r == '0) && (idx_r == '0);
        end
    end

    assign an_o         = an_r;
    assign seg_o        = seg_r;
    assign dp_o         = dp_r;
    assign frame_tick_o = frame_tick_r;

endmodule

// File: tb/tb_my7seg_scan_driver.sv
// Scoreboard bench for my7seg_scan_driver: a time-based reference model queues
// the expected pins for every cycle and a monitor compares them independently.
module tb_my7seg_scan_driver;

    localparam int ND   = 4;
    localparam int DIV  = 8;
    localparam int GRD  = 2;
    localparam int FRM  = DIV * ND;

    logic          ACLK;
    logic          ARESETN;
    logic [31:0]   digit_i;
    logic [7:0]    ctrl_i;
    logic          update_i;
    logic [3:0]    an_o;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic          frame_tick_o;

    my7seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (DIV),
        .GUARD_CYC      (GRD),
        .ACTIVE_LOW_AN  (1'b1),
        .ACTIVE_LOW_SEG (1'b1)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .digit_i      (digit_i),
        .ctrl_i       (ctrl_i),
        .update_i     (update_i),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .frame_tick_o (frame_tick_o)
    );

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc_cnt = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model: scanning time since scan start plus the displayed bytes.
    bit         m_scan = 1'b0;
    int         m_t = 0;
    logic [7:0] m_sh [ND] = '{8'h20, 8'h20, 8'h20, 8'h20};
    bit         m_pend = 1'b0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_cnt, act, req);
        end
    endtask

    // Monitor: compares the pins against whatever the model queued for this cycle.
    initial begin
        forever begin
            @(posedge ACLK);
            #2;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc < cyc_cnt) begin
                    check("stale_expectation", 8'(cyc_cnt - e.cyc), 8'd0);
                end else begin
                    check("an_o", {4'h0, an_o}, {4'h0, e.an});
                    check("seg_o", {1'b0, seg_o}, {1'b0, e.seg});
                    check("dp_o", {7'h0, dp_o}, {7'h0, e.dp});
                    check("frame_tick_o", {7'h0, frame_tick_o}, {7'h0, e.ft});
                end
            end
        end
    end

    // One clock: predict the pins after the coming edge, advance the model, wait for it.
    task automatic cycle();
        exp_t       e;
        int         presc, idx, pwm;
        logic [7:0] b;
        logic [3:0] oh;
        presc = m_t % DIV;
        idx   = (m_t / DIV) % ND;
        pwm   = m_t % 16;
        b     = m_sh[idx];
        e.cyc = cyc_cnt + 1;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.ft  = 1'b0;
        if (ARESETN && m_scan && ctrl_i[0]) begin
            if (presc >= GRD && pwm <= int'(ctrl_i[4:1]) && !b[5]) begin
                oh   = 4'b0001 << idx;
                e.an = ~oh;
            end
            e.seg = ~hex_tbl[b[3:0]];
            e.dp  = ~b[4];
            e.ft  = (m_t % FRM == 0);
        end
        exp_q.push_back(e);
        if (!ARESETN) begin
            m_scan = 1'b0;
            m_t    = 0;
            m_pend = 1'b0;
            for (int i = 0; i < ND; i++) m_sh[i] = 8'h20;
        end else if (!m_scan) begin
            if (update_i) begin
                for (int i = 0; i < ND; i++) m_sh[i] = digit_i[8*i +: 8];
                m_pend = 1'b0;
            end
            m_scan = ctrl_i[0];
            m_t    = 0;
        end else if (!ctrl_i[0]) begin
            m_scan = 1'b0;
            m_t    = 0;
            if (update_i) m_pend = 1'b1;
        end else begin
            if ((m_t % FRM == FRM - 1) && (m_pend || update_i)) begin
                for (int i = 0; i < ND; i++) m_sh[i] = digit_i[8*i +: 8];
                m_pend = 1'b0;
            end else if (update_i) begin
                m_pend = 1'b1;
            end
            m_t++;
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_update(input logic [31:0] d);
        digit_i  = d;
        update_i = 1'b1;
        cycle();
        update_i = 1'b0;
    endtask

    // Step until the model reaches the requested time within a frame, bounded.
    task automatic wait_frame_pos(input int pos, input string name);
        int n;
        n = 0;
        while (!(m_scan && (m_t % FRM == pos)) && n < 4 * FRM) begin
            cycle();
            n++;
        end
        check(name, 8'(n >= 4 * FRM), 8'd0);
    endtask

    initial begin
        ARESETN  = 1'b0;
        digit_i  = 32'h0;
        ctrl_i   = 8'h00;
        update_i = 1'b0;
        @(posedge ACLK);
        #1;
        run(3);
        ARESETN = 1'b1;
        run(50);

        // Basic scan of 0,1,2,3 at full brightness.
        pulse_update(32'h03020100);
        ctrl_i = 8'h1F;
        run(80);

        // Mid-frame write must wait for the next frame boundary.
        wait_frame_pos(DIV + 3, "reach_digit1");
        pulse_update(32'h0F0F0F0F);
        run(2 * FRM);

        // Reduced brightness.
        ctrl_i = 8'h07;
        run(256);

        // Blank on digit 2, dp with digit value 8 on digit 3.
        ctrl_i = 8'h1F;
        pulse_update(32'h18200504);
        run(2 * FRM);

        // Enable drop mid-slot, then restart from digit 0.
        wait_frame_pos(DIV + 4, "reach_mid_slot");
        ctrl_i = 8'h1E;
        run(5);
        ctrl_i = 8'h1F;
        run(FRM + 4);

        // Write landing exactly on the frame-wrap cycle.
        wait_frame_pos(FRM - 1, "reach_wrap");
        pulse_update(32'h0A0B0C0D);
        run(FRM + 4);

        // Randomized traffic, including mid-frame resets.
        for (int i = 0; i < 1500; i++) begin
            ctrl_i   = {3'($urandom), 4'($urandom), ($urandom_range(0, 39) != 0)};
            update_i = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) digit_i = $urandom;
            ARESETN  = ($urandom_range(0, 299) != 0);
            cycle();
        end
        ARESETN  = 1'b1;
        update_i = 1'b0;
        run(4);
        @(posedge ACLK);
        #3;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/my7seg_scan_driver.md
Name: my7seg_scan_driver

Overview:
Display back end of the my7seg AXI4-Lite peripheral. It consumes the digit and control register contents written over S00_AXI and drives a multiplexed common-anode 7-segment display. Functions: time-multiplexed digit scan, per-slot ghosting guard, 16-level PWM brightness, and tear-free shadow loading of register updates at frame boundaries. It sits directly downstream of the register bank in the same ACLK domain.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 100000, ACLK cycles per digit slot (must be greater than GUARD_CYC+1)
GUARD_CYC, 2, cycles at slot start with all anodes inactive
ACTIVE_LOW_AN, 1, anode output polarity (1 = active-low)
ACTIVE_LOW_SEG, 1, segment and dp output polarity (1 = active-low)

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
digit_i  in  8*NUM_DIGITS  per-digit byte from register bank: [3:0] hex value, [4] dp, [5] blank, [7:6] ignored
ctrl_i  in  8  [0] enable, [4:1] brightness 0..15, others ignored
update_i  in  1  one-cycle pulse on any register write
an_o  out  NUM_DIGITS  anode drives, one-hot active
seg_o  out  7  segments {g,f,e,d,c,b,a}
dp_o  out  1  decimal point
frame_tick_o  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge): an_o, seg_o and dp_o go to their inactive levels; frame_tick_o=0. The prescaler, digit index, PWM counter and pending flag clear to 0. The shadow register clears with every digit blank=1.
- FSM states:
  - IDLE: entered when enable=0. Outputs are inactive and all counters are held at 0. An update_i pulse loads the shadow from digit_i on the next edge.
  - SCAN: entered the cycle after enable=1 is seen.
  - SCAN→IDLE: enable=0 moves to IDLE on the next edge, mid-slot included. The pending update is kept.
- Prescaler: counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances.
  - Index wraps NUM_DIGITS-1 → 0; that wrap is the frame boundary.
  - frame_tick_o pulses the cycle after the index becomes 0.
- PWM counter: 4-bit, free-running in SCAN, wraps 15 → 0.
- Lit condition for the current index d: SCAN, prescaler ≥ GUARD_CYC, pwm_cnt ≤ brightness, and shadow[d].blank=0.
  - Brightness 15 lights for the whole window. Brightness 0 gives 1/16 duty.
- an_o: bit d active only when the lit condition holds. All anodes are inactive otherwise, including the guard window.
- seg_o and dp_o: decoded from shadow[d] during the entire slot, guard included, so segments settle before the anode turns on.
- All outputs are registered: 1-cycle latency from counter/shadow state to pins. Polarity is applied in the output register.
- Shadow update:
  - update_i in SCAN sets pending.
  - At the frame-boundary edge with pending=1, or with update_i high in that same cycle, the shadow samples digit_i and pending clears.
  - Multiple updates within one frame produce one load of the latest digit_i.
- ctrl_i is used live (not shadowed). A brightness change takes effect on the next cycle.
- Reset asserted mid-frame returns every output to the reset state at that edge. No partial state is retained.

Decomposition:
- Package my7seg_pkg holds:
  - the segment-pattern typedef (7-bit)
  - digit-byte field constants (VAL_LSB=0, DP_BIT=4, BLANK_BIT=5)
  - ctrl field constants
  - the 16-entry hex-to-segment constant table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71, active-high
- Sub-module my7seg_hex_decoder: combinational nibble → active-high pattern from the package table.
- All sequential logic lives in the top module.

Test Plan:
(Bench parameters: SCAN_DIV=8, GUARD_CYC=2, NUM_DIGITS=4, active-low outputs.)
1. Reset: hold ARESETN=0 for 3 cycles → an_o=4'hF, seg_o=7'h7F, dp_o=1, frame_tick_o=0. After release with enable=0, outputs are unchanged for 50 cycles.
2. Basic scan:
   - Stimulus: digit_i=32'h03020100, update_i pulse, ctrl_i=8'h1F.
   - Digit 0 slot: an_o=4'hF for 2 cycles, then 4'b1110 for 6 cycles with seg_o=7'h40.
   - Digit 1 slot: an_o=4'b1101 with seg_o=7'h79.
   - frame_tick_o pulses every 32 cycles.
3. Tear-free update:
   - Stimulus: while digit 1 is displayed, set digit_i=32'h0F0F0F0F and pulse update_i.
   - Digits 1..3 keep their old patterns for the rest of the frame.
   - From the next frame, every digit shows seg_o=7'h0E.
4. Brightness: ctrl_i=8'h07 (brightness 3) → over 256 cycles each digit's anode is active for exactly 4 of every 16 lit-window cycles. No anode is ever active during guard cycles.
5. Blank and dp:
   - Digit 2 byte 8'h20 → an_o[2] is never active.
   - Digit 3 byte 8'h18 → seg_o=7'h00 and dp_o=0 during its slot.
6. Enable drop and simultaneous events:
   - Deassert enable mid-slot → an_o=4'hF on the next output cycle. Re-enable → the scan restarts at digit 0, prescaler 0.
   - An update_i pulse coincident with the frame-wrap cycle loads that same cycle.
